// File: rtl/qei_snapshot_arbiter.sv
// qei_snapshot_arbiter
// Shares one 8-bit valid/ready byte stream between NCH quadrature-decoder
// channels. A requesting channel's 16-bit count (and direction) is captured
// atomically at the grant edge and then sent as a short byte frame.
// Requests are granted round-robin.
//
// Optional feature macro: QEI_SNAP_HDR_EN
//   defined   : frames are HDR, LO, HI (header = {1, dir, 0000, channel})
//   undefined : frames are LO, HI (direction is not transmitted)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   ch_count   NCH x 16-bit position counts, channel i at [16i+15:16i]
//   ch_dir     per-channel direction bit (1 = forward)
//   req        one-cycle snapshot request pulses, one per channel
//   out_data   frame byte
//   out_valid  out_data is valid
//   out_ready  consumer accepts the byte
//   out_last   final byte of a frame
//   grant_ch   channel owning the current frame, 0 when idle
//   busy       frame in progress
module qei_snapshot_arbiter #(
  parameter int NCH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*16-1:0] ch_count,
  input  logic [NCH-1:0]    ch_dir,
  input  logic [NCH-1:0]    req,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        grant_ch,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef QEI_SNAP_HDR_EN
    HDR  = 2'd1,
`endif
    LO   = 2'd2,
    HI   = 2'd3
  } state_t;

`ifdef QEI_SNAP_HDR_EN
  localparam state_t FIRST = HDR;
`else
  localparam state_t FIRST = LO;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] clr_mask;
  logic [1:0]     last_grant;
  logic [1:0]     winner;
  logic [1:0]     grant_r;
  logic [15:0]    win_cnt;
  logic [15:0]    snap_cnt;
  logic           grant_fire;

  // First pending channel at or after last+1, wrapping at NCH. The loop
  // walks from the farthest candidate to the nearest so the nearest wins.
  function automatic logic [1:0] rr_pick(input logic [NCH-1:0] p,
                                         input logic [1:0]     last);
    logic [1:0] w;
    w = 2'd0;
    for (int k = NCH; k >= 1; k--) begin
      for (int i = 0; i < NCH; i++) begin
        if (i == (int'(last) + k) % NCH && p[i]) w = 2'(i);
      end
    end
    return w;
  endfunction

  always_comb begin
    winner   = rr_pick(pending, last_grant);
    win_cnt  = '0;
    clr_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (winner == 2'(i)) win_cnt = ch_count[i*16 +: 16];
      clr_mask[i] = grant_fire && (winner == 2'(i));
    end
  end

`ifdef QEI_SNAP_HDR_EN
  logic win_dir;
  logic snap_dir;

  always_comb begin
    win_dir = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (winner == 2'(i)) win_dir = ch_dir[i];
    end
  end

  always_ff @(posedge clk) begin
    if (grant_fire) snap_dir <= win_dir;
  end
`else
  // Direction only travels in the header, so it has no sink here.
  logic unused_dir;
  assign unused_dir = ^ch_dir;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= 2'(NCH - 1);
    end else begin
      state <= state_nxt;
      // A request in the grant cycle re-arms the bit after it is cleared.
      pending <= (pending & ~clr_mask) | req;
      if (grant_fire) last_grant <= winner;
    end
  end

  // Snapshot registers: only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      snap_cnt <= win_cnt;
      grant_r  <= winner;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = 8'h00;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_fire = 1'b1;
          state_nxt  = FIRST;
        end
      end
`ifdef QEI_SNAP_HDR_EN
      HDR: begin
        out_valid = 1'b1;
        out_data  = {1'b1, snap_dir, 4'b0000, grant_r};
        if (out_ready) state_nxt = LO;
      end
`endif
      LO: begin
        out_valid = 1'b1;
        out_data  = snap_cnt[7:0];
        if (out_ready) state_nxt = HI;
      end
      HI: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = snap_cnt[15:8];
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_ch = (state == IDLE) ? 2'd0 : grant_r;

endmodule

// File: tb/tb_qei_snapshot_arbiter.sv
module tb_qei_snapshot_arbiter;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*16-1:0] ch_count;
  logic [NCH-1:0]    ch_dir;
  logic [NCH-1:0]    req;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [1:0]        grant_ch;
  logic              busy;

  always #5 clk = ~clk;

  qei_snapshot_arbiter #(.NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_count  (ch_count),
    .ch_dir    (ch_dir),
    .req       (req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .grant_ch  (grant_ch),
    .busy      (busy)
  );

  int tests  = 0;
  int failed = 0;

  // Transaction-level reference: a set of pending channels, a rotating
  // pointer, and the byte queue of the frame currently being sent.
  logic [NCH-1:0] m_pend;
  int             m_ptr;
  int             m_ch;
  logic [7:0]     m_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int          w;
    logic [15:0] c;
    if (!rst_n) begin
      m_pend = '0;
      m_ptr  = NCH - 1;
      m_ch   = 0;
      m_q.delete();
      return;
    end
    if (m_q.size() == 0) begin
      if (m_pend != '0) begin
        w = 0;
        for (int k = NCH; k >= 1; k--) if (m_pend[(m_ptr + k) % NCH]) w = (m_ptr + k) % NCH;
        c = ch_count[w*16 +: 16];
`ifdef QEI_SNAP_HDR_EN
        m_q.push_back({1'b1, ch_dir[w], 4'b0000, 2'(w)});
`endif
        m_q.push_back(c[7:0]);
        m_q.push_back(c[15:8]);
        m_pend[w] = 1'b0;
        m_ptr     = w;
        m_ch      = w;
      end
    end else if (out_ready) begin
      void'(m_q.pop_front());
    end
    m_pend = m_pend | req;
  endtask

  task automatic check_outputs();
    logic       v;
    logic [7:0] d;
    v = (m_q.size() != 0);
    d = v ? m_q[0] : 8'h00;
    chk("out_valid", 16'(out_valid), 16'(v));
    chk("busy",      16'(busy),      16'(v));
    chk("out_data",  16'(out_data),  16'(d));
    chk("out_last",  16'(out_last),  16'(m_q.size() == 1));
    chk("grant_ch",  16'(grant_ch),  v ? 16'(m_ch) : 16'd0);
  endtask

  task automatic step(input logic [NCH-1:0] r, input logic rdy, input logic rn);
    req       = r;
    out_ready = rdy;
    rst_n     = rn;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    req = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    ch_count  = '0;
    ch_dir    = '0;
    m_pend    = '0;
    m_ptr     = NCH - 1;
    m_ch      = 0;

    // Reset state
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data",  16'(out_data),  16'h00);
    chk("rst_last",  16'(out_last),  16'd0);
    chk("rst_grant", 16'(grant_ch),  16'd0);
    chk("rst_busy",  16'(busy),      16'd0);

    // Single request on channel 0
    ch_count[15:0] = 16'h1234;
    ch_dir         = 2'b01;
    step(2'b01, 1'b1, 1'b1);
    chk("sr_not_yet", 16'(out_valid), 16'd0);
    step(2'b00, 1'b1, 1'b1);
`ifdef QEI_SNAP_HDR_EN
    chk("sr_first", 16'(out_data), 16'h00C0);
`else
    chk("sr_first", 16'(out_data), 16'h0034);
`endif
    repeat (5) step(2'b00, 1'b1, 1'b1);

    // Simultaneous requests straight after reset, then again
    step(2'b00, 1'b1, 1'b0);
    ch_count = {16'hBEEF, 16'h0102};
    step(2'b11, 1'b1, 1'b1);
    repeat (10) step(2'b00, 1'b1, 1'b1);
    step(2'b11, 1'b1, 1'b1);
    repeat (10) step(2'b00, 1'b1, 1'b1);

    // Snapshot integrity under backpressure
    ch_count[15:0] = 16'h00FF;
    step(2'b01, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    ch_count[15:0] = 16'hABCD;
    repeat (5) step(2'b00, 1'b0, 1'b1);
`ifdef QEI_SNAP_HDR_EN
    chk("bp_hold", 16'(out_data), 16'h00C0);
`else
    chk("bp_hold", 16'(out_data), 16'h00FF);
`endif
    repeat (5) step(2'b00, 1'b1, 1'b1);

    // Request on a channel whose frame is stalled
    ch_count[31:16] = 16'h5555;
    ch_dir          = 2'b10;
    step(2'b10, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b1);
    ch_count[31:16] = 16'h6666;
    repeat (12) step(2'b00, 1'b1, 1'b1);

    // Reset while in HI with another request pending
    step(2'b01, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4 && !out_last; i++) step(2'b00, 1'b1, 1'b1);
    chk("mid_in_hi", 16'(out_last), 16'd1);
    step(2'b10, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0);
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_busy",  16'(busy),      16'd0);
    repeat (4) step(2'b00, 1'b1, 1'b1);
    step(2'b01, 1'b1, 1'b1);
    repeat (6) step(2'b00, 1'b1, 1'b1);

    // Channel 1, forward, count 0x8001
    ch_count[31:16] = 16'h8001;
    ch_dir          = 2'b10;
    step(2'b10, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
`ifdef QEI_SNAP_HDR_EN
    chk("hdr_first", 16'(out_data), 16'h00C1);
`else
    chk("hdr_first", 16'(out_data), 16'h0001);
`endif
    repeat (5) step(2'b00, 1'b1, 1'b1);

    // Randomized traffic with occasional resets
    repeat (600) begin
      ch_count = $urandom;
      ch_dir   = NCH'($urandom);
      step(NCH'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/qei_snapshot_arbiter.md
# qei_snapshot_arbiter

Readout controller that shares one 8-bit byte stream between NCH quadrature-decoder channels. It takes an atomic snapshot of a requesting channel's 16-bit position count and direction, then serialises it as a byte frame over a valid/ready handshake. It sits between the QEI counter instances and the pin or serial output mux, and grants requests round-robin.

## Interface
- NCH, default 2: number of QEI channels, legal range 1..4.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ch_count  in  NCH*16  per-channel position counts; channel i occupies bits [16i+15:16i].
- ch_dir  in  NCH  per-channel last-direction bit (1 = forward).
- req  in  NCH  one-cycle snapshot request pulses, one bit per channel.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte; a transfer happens when out_valid and out_ready are both high at a clk edge.
- out_last  out  1  marks the final byte of a frame.
- grant_ch  out  2  channel owning the current frame; 0 when idle.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Pending latch per channel:
  - req[i] high at an edge sets pending[i].
  - Granting channel i clears pending[i].
  - If req[i] arrives in the same cycle as the grant, the set wins and pending[i] stays 1.
- Arbitration:
  - Round-robin from last_grant+1, wrapping at NCH.
  - last_grant resets to NCH-1, so channel 0 wins first after reset.
- FSM states: IDLE, HDR (present only with the macro), LO, HI.
- IDLE:
  - When pending is nonzero, pick the winner and latch snap_cnt = ch_count[winner] and snap_dir = ch_dir[winner] at that edge.
  - Set grant_ch and last_grant, clear the winner's pending bit.
  - Next state is HDR if compiled in, otherwise LO.
- HDR: out_data = {1, snap_dir, 4'b0000, grant_ch}. On transfer -> LO.
- LO: out_data = snap_cnt[7:0]. On transfer -> HI.
- HI: out_data = snap_cnt[15:8], out_last = 1. On transfer -> IDLE.
- The snapshot is frozen for the whole frame. Changes on ch_count and ch_dir after the grant edge are ignored.
- Backpressure:
  - While out_ready is low, out_valid stays high and out_data, out_last and grant_ch hold stable.
  - out_valid never drops until the byte transfers.
- A request on a channel whose frame is in flight sets pending again, which produces a second frame later. Requests never merge into an in-flight frame.
- req bits at or above NCH do not exist. ch_count is treated as unsigned 16 bits.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0x00, grant_ch = 0, busy = 0.
  - pending = 0, last_grant = NCH-1, state = IDLE.
- Reset asserted mid-frame abandons the frame on the next edge: no out_last is emitted and pending requests are lost.
- Latency:
  - A req pulse at edge t sets pending.
  - The grant and snapshot happen at edge t+1.
  - out_valid is high from t+1, so the first byte is visible in the cycle after t+1.
- Frame length: 2 bytes, or 3 with the header. With out_ready held high, one byte transfers per cycle.
- The FSM always returns to IDLE for at least one cycle between frames. Back-to-back frames are therefore separated by exactly one out_valid-low cycle.
- out_last is high only while in HI, and only together with out_valid.

## Configuration
- QEI_SNAP_HDR_EN defined:
  - The HDR state and the header byte are compiled in.
  - Frames are 3 bytes: header, LO, HI.
- QEI_SNAP_HDR_EN undefined:
  - The HDR state is absent and frames are 2 bytes: LO, HI.
  - Direction is not transmitted; grant_ch is the only channel identification.

## Test plan
- Single request: NCH=2, ch_count[0]=0x1234, req=01 for one cycle, out_ready=1 -> bytes 0x34 then 0x12. out_last is high on 0x12 only, grant_ch=0, busy drops one cycle after the last transfer.
- Simultaneous requests: req=11 in one cycle right after reset -> full channel 0 frame, one idle cycle, then channel 1 frame. A following req=11 serves channel 0 first again (round-robin pointer at 1).
- Snapshot integrity and backpressure:
  - Grant channel 0 with count 0x00FF, then change ch_count[0] to 0xABCD.
  - Hold out_ready=0 for 5 cycles -> out_valid stays 1 and out_data stays 0xFF; the frame completes as 0xFF, 0x00.
- Request during own frame: req[1] pulses while channel 1's LO byte is stalled -> after that frame ends, exactly one further channel 1 frame is emitted, carrying the count at its new grant edge.
- Reset mid-frame: rst_n=0 for one edge while in HI -> next cycle out_valid=0, busy=0, pending=0. A new request then yields a fresh frame starting with LO, or with HDR when the header is compiled in.
- Header build: with QEI_SNAP_HDR_EN, channel 1, dir=1, count 0x8001 -> bytes 0xC1, 0x01, 0x80, with out_last on 0x80.
